io_bus_bridge_wide: RTL

Parametrised bridge from a wide Avalon-MM slave port (driven by the soft-CPU data master) to the 8-bit `io_*` peripheral bus. It replaces the fixed 8-bit io port:
- splits each 16/32-bit access into sequential byte cycles on enabled lanes;
- adds an ack timeout with sticky error reporting;
- synchronises `io_irq` into the CPU domain.

Sits between the CPU interconnect and the io bus decoder.

---
 rtl/io_bridge_pkg.sv | 19 +
 rtl/sync_bit.sv | 19 +
 rtl/io_bus_bridge_wide.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/io_bridge_pkg.sv
// Shared types and helpers for the wide-to-byte io bus bridge.
package io_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_DONE
    } t_io_bridge_state;

    // Read data substituted for a byte whose io cycle never acknowledged.
    localparam logic [7:0] C_TIMEOUT_FILL = 8'hFF;

    // Width of a lane pointer; a single-byte master still needs one bit.
    function automatic int lane_bits(input int data_bytes);
        return (data_bytes > 1) ? $clog2(data_bytes) : 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_pipe;

    // Shift the input through the synchroniser chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_pipe <= '0;
        else          sync_pipe <= {sync_pipe[STAGES-2:0], d};
    end

    assign q = sync_pipe[STAGES-1];
endmodule

// File: rtl/io_bus_bridge_wide.sv
// Wide Avalon-MM slave to 8-bit io bus: one strobe/ack byte cycle per enabled
// lane in ascending order, ack timeout with sticky error, synchronised irq.
module io_bus_bridge_wide
    import io_bridge_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 20,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATA_BYTES-1:0]   avs_byteenable,
    input  logic [8*DATA_BYTES-1:0] avs_writedata,
    output logic [8*DATA_BYTES-1:0] avs_readdata,
    output logic                    avs_waitrequest,
    output logic                    avs_irq,
    output logic [ADDR_W-1:0]       io_address,
    output logic                    io_read,
    output logic                    io_write,
    output logic [7:0]              io_wdata,
    input  logic [7:0]              io_rdata,
    input  logic                    io_ack,
    input  logic                    io_irq,
    output logic                    err_timeout,
    input  logic                    err_clear
);
    localparam int                LB         = lane_bits(DATA_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_BYTES - 1);

    t_io_bridge_state              state_q, state_d;
    logic [ADDR_W-1:0]             base_q;
    logic                          is_wr_q;
    logic [DATA_BYTES-1:0]         be_q;
    logic [DATA_BYTES-1:0][7:0]    wdata_q;
    logic [DATA_BYTES-1:0][7:0]    rdata_q;
    logic [LB-1:0]                 lane_q;
    logic [LB-1:0]                 first_lane;
    logic [LB-1:0]                 next_lane;
    logic                          more;
    logic                          lane_done;
    logic                          tmo_fire;
    logic                          req;

    assign req = avs_read | avs_write;

    // Lowest enabled lane of a new request, and next enabled lane above the current one.
    always_comb begin
        first_lane = '0;
        next_lane  = '0;
        more       = 1'b0;
        for (int i = DATA_BYTES - 1; i >= 0; i--) begin
            if (avs_byteenable[i]) first_lane = LB'(i);
            if (be_q[i] && (i > int'(lane_q))) begin
                next_lane = LB'(i);
                more      = 1'b1;
            end
        end
    end

    // State register; reset drops any strobe immediately and loses the transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d         = state_q;
        io_read         = 1'b0;
        io_write        = 1'b0;
        avs_waitrequest = 1'b1;
        lane_done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = (avs_byteenable == '0) ? S_DONE : S_STROBE;
            end
            S_STROBE: begin
                io_read  = ~is_wr_q;
                io_write = is_wr_q;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (io_ack || tmo_fire) begin
                    lane_done = 1'b1;
                    state_d   = more ? S_STROBE : S_DONE;
                end
            end
            S_DONE: begin
                avs_waitrequest = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ack timeout: counts WAIT cycles without ack, fires on the TIMEOUT-th one.
    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] tmo_cnt;

            // Restart on each strobe, count idle WAIT cycles.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)                        tmo_cnt <= '0;
                else if (state_q == S_STROBE)        tmo_cnt <= '0;
                else if (state_q == S_WAIT && !io_ack) tmo_cnt <= tmo_cnt + 1'b1;
            end

            assign tmo_fire = (state_q == S_WAIT) && !io_ack && (tmo_cnt == CW'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign tmo_fire = 1'b0;
        end
    endgenerate

    // Request latch and per-lane read capture; unenabled lanes stay 0x00.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            is_wr_q <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lane_q  <= '0;
        end else if (state_q == S_IDLE && req) begin
            base_q  <= avs_address & ALIGN_MASK;
            is_wr_q <= avs_write;
            be_q    <= avs_byteenable;
            wdata_q <= avs_writedata;
            rdata_q <= '0;
            lane_q  <= first_lane;
        end else if (lane_done) begin
            if (!is_wr_q) rdata_q[lane_q] <= io_ack ? io_rdata : C_TIMEOUT_FILL;
            if (more)     lane_q <= next_lane;
        end
    end

    // Sticky timeout flag; a timeout beats a coincident clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       err_timeout <= 1'b0;
        else if (tmo_fire)  err_timeout <= 1'b1;
        else if (err_clear) err_timeout <= 1'b0;
    end

    // Address and data come from latched state, so they hold from strobe to ack.
    assign io_address   = base_q + ADDR_W'(lane_q);
    assign io_wdata     = wdata_q[lane_q];
    assign avs_readdata = rdata_q;

    sync_bit #(.STAGES(2)) u_irq_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (io_irq),
        .q       (avs_irq)
    );
endmodule
